// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: history/index widths and the
// checkpoint entry captured at fetch for each in-flight branch.
package bpu_pkg;

    localparam int GHR_W = 4;
    localparam int IDX_W = 4;

    // Snapshot of the pre-shift history, the PHT index used for the
    // prediction, and the predicted direction.
    typedef struct packed {
        logic [GHR_W-1:0] ghr;
        logic [IDX_W-1:0] idx;
        logic             pred;
    } ckpt_entry_t;

    // Shift one new outcome into the youngest end of a history register.
    function automatic logic [GHR_W-1:0] shiftHistory(input logic [GHR_W-1:0] hist,
                                                      input logic             bitIn);
        return {hist[GHR_W-2:0], bitIn};
    endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Checkpoint queue for in-flight branches. Oldest entry is always visible
// on o_rdData; i_clear flushes everything when the front end is redirected.
module ghr_ckpt_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  ckpt_entry_t              i_wrData,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output ckpt_entry_t              o_rdData,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    ckpt_entry_t     r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_doPush;
    logic            w_doPop;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_doPush = i_push & ~w_full & ~i_clear;
    assign w_doPop  = i_pop & ~w_empty & ~i_clear;

    assign o_rdData = r_mem[r_rdPtr];
    assign o_count  = r_count;
    assign o_full   = w_full;

    // Entry storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; clear empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ghr_spec_ctrl.sv
// Speculative global-history controller for the gshare predictor.
// Fetch advances a speculative history and checkpoints it; execute retires
// branches in order, maintains the committed history, repairs the
// speculative history on a wrong prediction and issues PHT training writes.
module ghr_spec_ctrl
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_br_valid,
    input  logic                     fetch_pred_taken,
    input  logic [31:0]              fetch_pc,
    output logic [IDX_W-1:0]         fetch_index,
    output logic                     fetch_stall,
    input  logic                     ex_br_valid,
    input  logic                     ex_taken,
    output logic                     ex_stall,
    output logic                     mispredict,
    output logic [GHR_W-1:0]         spec_ghr,
    output logic [GHR_W-1:0]         arch_ghr,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [IDX_W-1:0]         upd_index,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   ckpt_count,
    output logic                     err_underflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [GHR_W-1:0]  r_specGhr;
    logic [GHR_W-1:0]  r_archGhr;
    logic              r_mispredict;
    logic              r_updValid;
    logic [IDX_W-1:0]  r_updIndex;
    logic              r_updTaken;
    logic              r_errUnderflow;

    ckpt_entry_t       w_head;
    ckpt_entry_t       w_pushEntry;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic [IDX_W-1:0]  w_fetchIndex;
    logic              w_exStall;
    logic              w_push;
    logic              w_resolveTry;
    logic              w_resolve;
    logic              w_underflow;
    logic              w_mispred;
    logic              w_fifoPush;
    logic              w_fifoPop;
    logic              w_unusedPcBits;
    logic              w_unusedHeadMsb;

    // Only the low PC bits feed the gshare hash; the head's oldest history bit
    // shifts out during repair.
    assign w_unusedPcBits  = ^fetch_pc[31:IDX_W];
    assign w_unusedHeadMsb = w_head.ghr[GHR_W-1];

    assign w_fetchIndex = fetch_pc[IDX_W-1:0] ^ r_specGhr;
    assign w_exStall    = r_updValid & ~upd_ready;

    assign w_push       = fetch_br_valid & ~w_full;
    assign w_resolveTry = ex_br_valid & ~w_exStall;
    assign w_resolve    = w_resolveTry & (w_count != '0);
    assign w_underflow  = w_resolveTry & (w_count == '0);
    assign w_mispred    = w_resolve & (w_head.pred != ex_taken);

    // A wrong prediction flushes the queue, so any same-cycle fetch is wrong-path.
    assign w_fifoPush   = w_push & ~w_mispred;
    assign w_fifoPop    = w_resolve & ~w_mispred;

    assign w_pushEntry.ghr  = r_specGhr;
    assign w_pushEntry.idx  = w_fetchIndex;
    assign w_pushEntry.pred = fetch_pred_taken;

    ghr_ckpt_fifo #(
        .DEPTH (DEPTH)
    ) u_ckptFifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_fifoPush),
        .i_wrData (w_pushEntry),
        .i_pop    (w_fifoPop),
        .i_clear  (w_mispred),
        .o_rdData (w_head),
        .o_count  (w_count),
        .o_full   (w_full)
    );

    // Speculative history: repaired from the head checkpoint on a wrong
    // prediction, otherwise advanced by each accepted fetch prediction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_specGhr <= '0;
        end else if (w_mispred) begin
            r_specGhr <= shiftHistory(w_head.ghr, ex_taken);
        end else if (w_push) begin
            r_specGhr <= shiftHistory(r_specGhr, fetch_pred_taken);
        end
    end

    // Committed history advances with every resolved branch outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_archGhr <= '0;
        end else if (w_resolve) begin
            r_archGhr <= shiftHistory(r_archGhr, ex_taken);
        end
    end

    // One-cycle redirect pulse, and sticky flag for a resolve with nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict   <= 1'b0;
            r_errUnderflow <= 1'b0;
        end else begin
            r_mispredict <= w_mispred;
            if (w_underflow) begin
                r_errUnderflow <= 1'b1;
            end
        end
    end

    // PHT training request: loads on resolve, holds while the PHT is busy,
    // and drops once accepted unless a new resolve reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_updValid <= 1'b0;
            r_updIndex <= '0;
            r_updTaken <= 1'b0;
        end else if (w_resolve) begin
            r_updValid <= 1'b1;
            r_updIndex <= w_head.idx;
            r_updTaken <= ex_taken;
        end else if (r_updValid & upd_ready) begin
            r_updValid <= 1'b0;
            r_updIndex <= '0;
            r_updTaken <= 1'b0;
        end
    end

    assign fetch_index   = w_fetchIndex;
    assign fetch_stall   = w_full;
    assign ex_stall      = w_exStall;
    assign mispredict    = r_mispredict;
    assign spec_ghr      = r_specGhr;
    assign arch_ghr      = r_archGhr;
    assign upd_valid     = r_updValid;
    assign upd_index     = r_updIndex;
    assign upd_taken     = r_updTaken;
    assign ckpt_count    = w_count;
    assign err_underflow = r_errUnderflow;

endmodule
